// File: rtl/mul_arb_pkg.sv
// Shared types for the multiplier arbiter: in-flight tag layout and the
// funct3 encoding that selects the low product half.
package mul_arb_pkg;

    typedef struct packed {
        logic vld;
        logic id;
        logic hi;
    } mul_tag_t;

    localparam logic [2:0] FUNCT3_MUL = 3'b000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational grant, registered last winner.
// Latency 0; the pointer only moves when the grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       issue,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt[0] = req[0] & (~req[1] | last_q);
        gnt[1] = req[1] & (~req[0] | ~last_q);
        last_d = last_q;
        if (issue) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mul_arb.sv
// Arbitrates two requesters onto a shared pipelined multiplier, tags in-flight ops,
// returns the selected product half LAT cycles after issue; a blocked head stalls everything.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req0Valid,
    input  logic              Req1Valid,
    output logic              Req0Ready,
    output logic              Req1Ready,
    input  logic [XLEN-1:0]   Req0SrcA,
    input  logic [XLEN-1:0]   Req0SrcB,
    input  logic [XLEN-1:0]   Req1SrcA,
    input  logic [XLEN-1:0]   Req1SrcB,
    input  logic [2:0]        Req0Funct3,
    input  logic [2:0]        Req1Funct3,
    input  logic              Flush0,
    input  logic              Flush1,
    output logic [XLEN-1:0]   MulSrcA,
    output logic [XLEN-1:0]   MulSrcB,
    output logic [2:0]        MulFunct3,
    output logic              MulStall,
    input  logic [2*XLEN-1:0] MulProd,
    output logic              Rsp0Valid,
    output logic              Rsp1Valid,
    input  logic              Rsp0Ready,
    input  logic              Rsp1Ready,
    output logic [XLEN-1:0]   Rsp0Result,
    output logic [XLEN-1:0]   Rsp1Result
);

    logic [1:0]      req_vld, flush, rsp_rdy, elig, gnt, req_rdy;
    logic            stall, issue, issue_id;
    logic [XLEN-1:0] iss_a, iss_b, result;
    logic [2:0]      iss_f3;
    mul_tag_t        tag_q [LAT];
    mul_tag_t        tag_d [LAT];
    mul_tag_t        tag_f [LAT];
    mul_tag_t        head;

    assign req_vld = {Req1Valid, Req0Valid};
    assign flush   = {Flush1, Flush0};
    assign rsp_rdy = {Rsp1Ready, Rsp0Ready};
    assign elig    = req_vld & ~flush;

    // Flush kills matching tags in the same cycle, so a flushed head never stalls.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            tag_f[k] = tag_q[k];
            if (flush[tag_q[k].id]) begin
                tag_f[k].vld = 1'b0;
            end
        end
        head  = tag_f[LAT-1];
        stall = head.vld & ~rsp_rdy[head.id];
    end

    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .issue (issue),
        .gnt   (gnt)
    );

    always_comb begin
        req_rdy  = gnt & {2{~stall & ~reset}};
        issue    = |req_rdy;
        issue_id = req_rdy[1];
        iss_a    = '0;
        iss_b    = '0;
        iss_f3   = FUNCT3_MUL;
        if (req_rdy[1]) begin
            iss_a  = Req1SrcA;
            iss_b  = Req1SrcB;
            iss_f3 = Req1Funct3;
        end else if (req_rdy[0]) begin
            iss_a  = Req0SrcA;
            iss_b  = Req0SrcB;
            iss_f3 = Req0Funct3;
        end
    end

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            tag_d[k] = tag_f[k];
        end
        if (!stall) begin
            tag_d[0].vld = issue;
            tag_d[0].id  = issue_id;
            tag_d[0].hi  = (iss_f3 != FUNCT3_MUL);
            for (int k = 1; k < LAT; k++) begin
                tag_d[k] = tag_f[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign result     = head.hi ? MulProd[2*XLEN-1:XLEN] : MulProd[XLEN-1:0];
    assign Req0Ready  = req_rdy[0];
    assign Req1Ready  = req_rdy[1];
    assign MulSrcA    = iss_a;
    assign MulSrcB    = iss_b;
    assign MulFunct3  = iss_f3;
    assign MulStall   = stall;
    assign Rsp0Valid  = head.vld & ~head.id;
    assign Rsp1Valid  = head.vld & head.id;
    assign Rsp0Result = result;
    assign Rsp1Result = result;

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: a LAT=1 instance with a response scoreboard and a LAT=2
// instance for the flush and mid-operation reset sequences.
module tb_mul_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] f3);
        logic [127:0] ae, be;
        ae = (f3 == 3'b001 || f3 == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
        be = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
        return ae * be;
    endfunction

    function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] f3);
        logic [127:0] p;
        p = ref_mul(a, b, f3);
        return (f3 == 3'b000) ? p[63:0] : p[127:64];
    endfunction

    // ---------------- DUT A: LAT=1 ----------------
    logic a_Req0Valid, a_Req1Valid, a_Req0Ready, a_Req1Ready;
    logic [63:0] a_Req0SrcA, a_Req0SrcB, a_Req1SrcA, a_Req1SrcB;
    logic [2:0] a_Req0Funct3, a_Req1Funct3, a_MulFunct3;
    logic a_Flush0, a_Flush1, a_MulStall;
    logic [63:0] a_MulSrcA, a_MulSrcB;
    logic [127:0] a_MulProd, a_p1 = '0;
    logic a_Rsp0Valid, a_Rsp1Valid, a_Rsp0Ready, a_Rsp1Ready;
    logic [63:0] a_Rsp0Result, a_Rsp1Result;

    mul_arb #(.XLEN(64), .LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .Req0Valid(a_Req0Valid), .Req1Valid(a_Req1Valid),
        .Req0Ready(a_Req0Ready), .Req1Ready(a_Req1Ready),
        .Req0SrcA(a_Req0SrcA), .Req0SrcB(a_Req0SrcB),
        .Req1SrcA(a_Req1SrcA), .Req1SrcB(a_Req1SrcB),
        .Req0Funct3(a_Req0Funct3), .Req1Funct3(a_Req1Funct3),
        .Flush0(a_Flush0), .Flush1(a_Flush1),
        .MulSrcA(a_MulSrcA), .MulSrcB(a_MulSrcB), .MulFunct3(a_MulFunct3),
        .MulStall(a_MulStall), .MulProd(a_MulProd),
        .Rsp0Valid(a_Rsp0Valid), .Rsp1Valid(a_Rsp1Valid),
        .Rsp0Ready(a_Rsp0Ready), .Rsp1Ready(a_Rsp1Ready),
        .Rsp0Result(a_Rsp0Result), .Rsp1Result(a_Rsp1Result)
    );

    always @(posedge clk) if (!a_MulStall) a_p1 <= ref_mul(a_MulSrcA, a_MulSrcB, a_MulFunct3);
    assign a_MulProd = a_p1;

    // ---------------- DUT B: LAT=2 ----------------
    logic b_Req0Valid, b_Req1Valid, b_Req0Ready, b_Req1Ready;
    logic [63:0] b_Req0SrcA, b_Req0SrcB, b_Req1SrcA, b_Req1SrcB;
    logic [2:0] b_Req0Funct3, b_Req1Funct3, b_MulFunct3;
    logic b_Flush0, b_Flush1, b_MulStall;
    logic [63:0] b_MulSrcA, b_MulSrcB;
    logic [127:0] b_MulProd, b_p1 = '0, b_p2 = '0;
    logic b_Rsp0Valid, b_Rsp1Valid, b_Rsp0Ready, b_Rsp1Ready;
    logic [63:0] b_Rsp0Result, b_Rsp1Result;

    mul_arb #(.XLEN(64), .LAT(2)) dut_b (
        .clk(clk), .reset(reset),
        .Req0Valid(b_Req0Valid), .Req1Valid(b_Req1Valid),
        .Req0Ready(b_Req0Ready), .Req1Ready(b_Req1Ready),
        .Req0SrcA(b_Req0SrcA), .Req0SrcB(b_Req0SrcB),
        .Req1SrcA(b_Req1SrcA), .Req1SrcB(b_Req1SrcB),
        .Req0Funct3(b_Req0Funct3), .Req1Funct3(b_Req1Funct3),
        .Flush0(b_Flush0), .Flush1(b_Flush1),
        .MulSrcA(b_MulSrcA), .MulSrcB(b_MulSrcB), .MulFunct3(b_MulFunct3),
        .MulStall(b_MulStall), .MulProd(b_MulProd),
        .Rsp0Valid(b_Rsp0Valid), .Rsp1Valid(b_Rsp1Valid),
        .Rsp0Ready(b_Rsp0Ready), .Rsp1Ready(b_Rsp1Ready),
        .Rsp0Result(b_Rsp0Result), .Rsp1Result(b_Rsp1Result)
    );

    always @(posedge clk) begin
        if (!b_MulStall) begin
            b_p1 <= ref_mul(b_MulSrcA, b_MulSrcB, b_MulFunct3);
            b_p2 <= b_p1;
        end
    end
    assign b_MulProd = b_p2;

    // ---------------- scoreboard for DUT A ----------------
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int iss_log[$];
    int rsp_log[$];

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (a_Rsp0Valid && a_Rsp0Ready) begin
                rsp_log.push_back(0);
                chk("sb_rsp0_expected", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) chk("sb_rsp0_result", a_Rsp0Result, q0.pop_front());
            end
            if (a_Rsp1Valid && a_Rsp1Ready) begin
                rsp_log.push_back(1);
                chk("sb_rsp1_expected", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) chk("sb_rsp1_result", a_Rsp1Result, q1.pop_front());
            end
            if (a_Req0Valid && a_Req0Ready) begin
                iss_log.push_back(0);
                q0.push_back(ref_res(a_Req0SrcA, a_Req0SrcB, a_Req0Funct3));
            end
            if (a_Req1Valid && a_Req1Ready) begin
                iss_log.push_back(1);
                q1.push_back(ref_res(a_Req1SrcA, a_Req1SrcB, a_Req1Funct3));
            end
        end
    end

    typedef struct {
        logic        sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, got, found, cnt;
        logic rdy, vld;
        logic [63:0] res;

        vecs[0] = '{1'b0, 64'd3, 64'd5, 3'b000, 64'd15};
        vecs[1] = '{1'b1, 64'h8000_0000_0000_0000, 64'd2, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{1'b1, 64'h8000_0000_0000_0000, 64'd2, 3'b011, 64'h0000_0000_0000_0001};
        vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 64'd1};
        vecs[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011,
                    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 64'd0};

        reset = 1'b1;
        a_Req0Valid = 1'b1; a_Req1Valid = 1'b1;
        a_Req0SrcA = 64'd7; a_Req0SrcB = 64'd9; a_Req0Funct3 = 3'b001;
        a_Req1SrcA = 64'd4; a_Req1SrcB = 64'd6; a_Req1Funct3 = 3'b001;
        a_Flush0 = 1'b0; a_Flush1 = 1'b0; a_Rsp0Ready = 1'b1; a_Rsp1Ready = 1'b1;
        b_Req0Valid = 1'b0; b_Req1Valid = 1'b0;
        b_Req0SrcA = '0; b_Req0SrcB = '0; b_Req0Funct3 = 3'b000;
        b_Req1SrcA = '0; b_Req1SrcB = '0; b_Req1Funct3 = 3'b000;
        b_Flush0 = 1'b0; b_Flush1 = 1'b0; b_Rsp0Ready = 1'b1; b_Rsp1Ready = 1'b1;

        // Outputs while held in reset, with both requests pending.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'({a_Req1Ready, a_Req0Ready}), 64'd0);
        chk("rst_rsp_valid", 64'({a_Rsp1Valid, a_Rsp0Valid}), 64'd0);
        chk("rst_mul_stall", 64'(a_MulStall), 64'd0);
        chk("rst_mul_srca", a_MulSrcA, 64'd0);
        chk("rst_mul_srcb", a_MulSrcB, 64'd0);
        chk("rst_mul_funct3", 64'(a_MulFunct3), 64'd0);

        // Alternating issue from reset, both requesters always valid.
        tick();
        a_Req0Funct3 = 3'b000; a_Req1Funct3 = 3'b000;
        iss_log.delete(); rsp_log.delete();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_Req0SrcA = 64'(10 + i); a_Req0SrcB = 64'd3;
            a_Req1SrcA = 64'(20 + i); a_Req1SrcB = 64'd5;
            @(negedge clk);
            chk("alt_grant", 64'({a_Req1Ready, a_Req0Ready}), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
        end
        a_Req0Valid = 1'b0; a_Req1Valid = 1'b0;
        repeat (3) tick();
        chk("alt_drained", 64'(q0.size() + q1.size()), 64'd0);
        chk("alt_rsp_count", 64'(rsp_log.size()), 64'd8);
        for (int i = 0; i < rsp_log.size(); i++) chk("alt_rsp_order", 64'(rsp_log[i]), 64'(i % 2));

        // Table of single ops: result, exact latency, other requester silent.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].sel) begin
                a_Req1Valid = 1'b1; a_Req1SrcA = vecs[i].a; a_Req1SrcB = vecs[i].b;
                a_Req1Funct3 = vecs[i].f3;
            end else begin
                a_Req0Valid = 1'b1; a_Req0SrcA = vecs[i].a; a_Req0SrcB = vecs[i].b;
                a_Req0Funct3 = vecs[i].f3;
            end
            @(negedge clk);
            c0 = cyc;
            rdy = vecs[i].sel ? a_Req1Ready : a_Req0Ready;
            chk("vec_ready", 64'(rdy), 64'd1);
            tick();
            a_Req0Valid = 1'b0; a_Req1Valid = 1'b0;
            found = 0;
            for (int j = 0; j < 8 && found == 0; j++) begin
                @(negedge clk);
                vld = vecs[i].sel ? a_Rsp1Valid : a_Rsp0Valid;
                if (vld) begin
                    found = 1;
                    res = vecs[i].sel ? a_Rsp1Result : a_Rsp0Result;
                    chk("vec_latency", 64'(cyc - c0), 64'd1);
                    chk("vec_result", res, vecs[i].exp);
                    chk("vec_other_silent", 64'(vecs[i].sel ? a_Rsp0Valid : a_Rsp1Valid), 64'd0);
                end
            end
            chk("vec_response_seen", 64'(found), 64'd1);
            tick();
        end

        // Held response: stall, both readies low, stable result, then one delivery.
        a_Rsp0Ready = 1'b0;
        a_Req0Valid = 1'b1; a_Req0SrcA = 64'd7; a_Req0SrcB = 64'd6; a_Req0Funct3 = 3'b000;
        @(negedge clk);
        chk("stall_issue", 64'(a_Req0Ready), 64'd1);
        tick();
        a_Req0Valid = 1'b0;
        a_Req1Valid = 1'b1; a_Req1SrcA = 64'd9; a_Req1SrcB = 64'd9; a_Req1Funct3 = 3'b000;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(a_Rsp0Valid), 64'd1);
            chk("stall_mulstall", 64'(a_MulStall), 64'd1);
            chk("stall_readies", 64'({a_Req1Ready, a_Req0Ready}), 64'd0);
            chk("stall_result", a_Rsp0Result, 64'd42);
            tick();
        end
        a_Rsp0Ready = 1'b1;
        @(negedge clk);
        chk("release_rsp_valid", 64'(a_Rsp0Valid), 64'd1);
        chk("release_mulstall", 64'(a_MulStall), 64'd0);
        chk("release_req1_ready", 64'(a_Req1Ready), 64'd1);
        tick();
        a_Req1Valid = 1'b0;
        @(negedge clk);
        chk("after_rsp0_gone", 64'(a_Rsp0Valid), 64'd0);
        chk("after_rsp1_valid", 64'(a_Rsp1Valid), 64'd1);
        chk("after_rsp1_result", a_Rsp1Result, 64'd81);
        tick();
        tick();
        chk("stall_drained", 64'(q0.size() + q1.size()), 64'd0);

        // LAT=2: req1 op, then req0 op with Flush1 in the same cycle.
        b_Req1Valid = 1'b1; b_Req1SrcA = 64'd3; b_Req1SrcB = 64'd3; b_Req1Funct3 = 3'b000;
        @(negedge clk);
        chk("l2_req1_issue", 64'(b_Req1Ready), 64'd1);
        tick();
        b_Req1Valid = 1'b0; b_Flush1 = 1'b1;
        b_Req0Valid = 1'b1; b_Req0SrcA = 64'd4; b_Req0SrcB = 64'd5; b_Req0Funct3 = 3'b000;
        @(negedge clk);
        chk("l2_req0_issue_under_flush1", 64'(b_Req0Ready), 64'd1);
        c0 = cyc;
        cnt = 0;
        got = -1;
        if (b_Rsp1Valid) cnt++;
        tick();
        b_Req0Valid = 1'b0; b_Flush1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (b_Rsp1Valid) cnt++;
            if (b_Rsp0Valid && got < 0) begin
                got = cyc - c0;
                chk("l2_rsp0_result", b_Rsp0Result, 64'd20);
            end
        end
        chk("l2_rsp1_never", 64'(cnt), 64'd0);
        chk("l2_rsp0_latency", 64'(got), 64'd2);

        // LAT=2: reset with two ops in flight.
        tick();
        b_Req1Valid = 1'b1; b_Req1SrcA = 64'd2; b_Req1SrcB = 64'd2; b_Req1Funct3 = 3'b000;
        @(negedge clk);
        chk("rst2_req1_issue", 64'(b_Req1Ready), 64'd1);
        tick();
        b_Req1Valid = 1'b0;
        b_Req0Valid = 1'b1; b_Req0SrcA = 64'd5; b_Req0SrcB = 64'd5; b_Req0Funct3 = 3'b000;
        @(negedge clk);
        chk("rst2_req0_issue", 64'(b_Req0Ready), 64'd1);
        tick();
        b_Req0Valid = 1'b0;
        #1;
        chk("rst2_head_before_reset", 64'(b_Rsp1Valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst2_rsp_drop", 64'({b_Rsp1Valid, b_Rsp0Valid}), 64'd0);
        chk("rst2_stall_drop", 64'(b_MulStall), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        cnt = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (b_Rsp0Valid || b_Rsp1Valid) cnt++;
        end
        chk("rst2_no_stale_rsp", 64'(cnt), 64'd0);
        tick();
        b_Req0Valid = 1'b1; b_Req1Valid = 1'b1;
        @(negedge clk);
        chk("rst2_first_grant", 64'({b_Req1Ready, b_Req0Ready}), 64'd1);
        tick();
        b_Req0Valid = 1'b0; b_Req1Valid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
